// File: rtl/div_if.sv
// Start/busy/done bundle between the EX-stage control and the iterative divider.
// An operation is requested by iStart while oBusy=0; oDone pulses once when results are valid.
interface div_if #(parameter int WIDTH = 32);
    logic             iStart;
    logic             iSigned;
    logic [WIDTH-1:0] iDividend;
    logic [WIDTH-1:0] iDivisor;
    logic             oBusy;
    logic             oDone;
    logic [WIDTH-1:0] oQuotient;
    logic [WIDTH-1:0] oRemainder;
    logic             oDivZero;

    modport master (
        output iStart, iSigned, iDividend, iDivisor,
        input  oBusy, oDone, oQuotient, oRemainder, oDivZero
    );

    modport slave (
        input  iStart, iSigned, iDividend, iDivisor,
        output oBusy, oDone, oQuotient, oRemainder, oDivZero
    );
endinterface

// File: rtl/div_unit.sv
// Restoring radix-2 divider for MIPS DIV/DIVU: WIDTH iterations on operand magnitudes,
// sign fix-up on the way into DONE. Quotient -> LO, remainder -> HI.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic       iClk,
    input  logic       iReset,
    div_if.slave       bus,
    output logic [1:0] oDbgState
);
    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic [CW-1:0]    r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_q_out;
    logic [WIDTH-1:0] r_r_out;
    logic             r_dz;

    logic             w_sign_a;
    logic             w_sign_b;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_dz;
    logic             w_accept;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_quo_nx;

    assign w_sign_a = bus.iSigned & bus.iDividend[WIDTH-1];
    assign w_sign_b = bus.iSigned & bus.iDivisor[WIDTH-1];
    assign w_mag_a  = w_sign_a ? -bus.iDividend : bus.iDividend;
    assign w_mag_b  = w_sign_b ? -bus.iDivisor : bus.iDivisor;
    assign w_dz     = (bus.iDivisor == '0);
    // DONE accepts a new request exactly like IDLE; only RUN ignores iStart.
    assign w_accept = bus.iStart & (r_state != RUN);

    // The partial remainder is always below the divisor, so a WIDTH+1-bit
    // difference has an unambiguous sign bit even for divisors >= 2^(WIDTH-1).
    assign w_shift  = {r_rem, r_quo[WIDTH-1]};
    assign w_diff   = w_shift - {1'b0, r_dvs};
    assign w_rem_nx = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_quo_nx = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};

    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        bus.oBusy  = 1'b0;
        bus.oDone  = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                bus.oDone = (r_state == DONE);
                if (bus.iStart) begin
                    w_next = w_dz ? DONE : RUN;
                end else begin
                    w_next = IDLE;
                end
            end
            RUN: begin
                bus.oBusy = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_next = DONE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_q_out <= '0;
            r_r_out <= '0;
            r_dz    <= 1'b0;
        end else if (w_accept) begin
            r_rem   <= '0;
            r_quo   <= w_mag_a;
            r_dvs   <= w_mag_b;
            r_cnt   <= CNT_INIT;
            r_neg_q <= w_sign_a ^ w_sign_b;
            r_neg_r <= w_sign_a;
            if (w_dz) begin
                r_q_out <= '1;
                r_r_out <= bus.iDividend;
                r_dz    <= 1'b1;
            end
        end else if (r_state == RUN) begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt - CNT_LAST;
            if (r_cnt == CNT_LAST) begin
                r_q_out <= r_neg_q ? -w_quo_nx : w_quo_nx;
                r_r_out <= r_neg_r ? -w_rem_nx : w_rem_nx;
                r_dz    <= 1'b0;
            end
        end
    end

    assign bus.oQuotient  = r_q_out;
    assign bus.oRemainder = r_r_out;
    assign bus.oDivZero   = r_dz;
    assign oDbgState      = r_state;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: a table of hand-computed DIV/DIVU vectors plus
// sequences for ignored iStart while busy, reset mid-RUN and back-to-back starts.
module tb_div_unit;
    localparam int W       = 32;
    localparam int TIMEOUT = 100;

    typedef struct {
        string      name;
        logic       sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic       dz;
        int         lat;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         n_vec;
    int         n_fail;
    logic [W-1:0] exp_q[$];
    vec_t       vecs[12];

    div_if #(.WIDTH(W)) bus ();

    div_unit #(.WIDTH(W)) dut (
        .iClk      (clk),
        .iReset    (rst),
        .bus       (bus),
        .oDbgState (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_done(inout int lat);
        while (!bus.oDone && lat < TIMEOUT) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Present one request for a single edge, then scramble inputs to prove they are not reused.
    task automatic run_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        @(negedge clk);
        bus.iStart    = 1'b1;
        bus.iSigned   = sgn;
        bus.iDividend = a;
        bus.iDivisor  = b;
        @(posedge clk);
        #1;
        bus.iStart    = 1'b0;
        bus.iDividend = $urandom;
        bus.iDivisor  = $urandom;
        bus.iSigned   = 1'($urandom_range(0, 1));
        lat = 1;
        wait_done(lat);
    endtask

    initial begin
        int lat;
        int done_seen;
        logic [W-1:0] eq;
        logic [W-1:0] er;

        n_vec  = 0;
        n_fail = 0;
        vecs[0]  = '{"divu_100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33};
        vecs[1]  = '{"div_m7_2",     1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 33};
        vecs[2]  = '{"div_7_m2",     1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 33};
        vecs[3]  = '{"div_ovf",      1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 33};
        vecs[4]  = '{"divu_ovf_ops", 1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0, 33};
        vecs[5]  = '{"div_m7_0",     1'b1, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF9,   1'b1, 1};
        vecs[6]  = '{"divu_5_0",     1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, 1};
        vecs[7]  = '{"divu_max_1",   1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 33};
        vecs[8]  = '{"div_m8_m3",    1'b1, 32'hFFFFFFF8,   32'hFFFFFFFD,   32'd2,          32'hFFFFFFFE,   1'b0, 33};
        vecs[9]  = '{"divu_3_10",    1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          1'b0, 33};
        vecs[10] = '{"div_m6_3",     1'b1, 32'hFFFFFFFA,   32'd3,          32'hFFFFFFFE,   32'd0,          1'b0, 33};
        vecs[11] = '{"divu_big_div", 1'b0, 32'hFFFFFFFE,   32'h80000000,   32'd1,          32'h7FFFFFFE,   1'b0, 33};

        // Clock/reset
        bus.iStart    = 1'b0;
        bus.iSigned   = 1'b0;
        bus.iDividend = '0;
        bus.iDivisor  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy",  W'(bus.oBusy),    '0);
        check("rst_done",  W'(bus.oDone),    '0);
        check("rst_q",     bus.oQuotient,    '0);
        check("rst_r",     bus.oRemainder,   '0);
        check("rst_dz",    W'(bus.oDivZero), '0);
        check("rst_state", W'(dbg_state),    '0);

        // Table-driven vectors
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back(vecs[i].q);
            exp_q.push_back(vecs[i].r);
            run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, lat);
            eq = exp_q.pop_front();
            er = exp_q.pop_front();
            check({vecs[i].name, "_lat"}, W'(lat), W'(vecs[i].lat));
            check({vecs[i].name, "_q"},   bus.oQuotient,    eq);
            check({vecs[i].name, "_r"},   bus.oRemainder,   er);
            check({vecs[i].name, "_dz"},  W'(bus.oDivZero), W'(vecs[i].dz));
            @(posedge clk);
            #1;
            check({vecs[i].name, "_pulse"}, W'(bus.oDone), '0);
            check({vecs[i].name, "_hold"},  bus.oQuotient, eq);
        end

        // iStart with new operands mid-RUN must be ignored
        @(negedge clk);
        bus.iStart = 1'b1; bus.iSigned = 1'b0; bus.iDividend = 32'd100; bus.iDivisor = 32'd7;
        @(posedge clk);
        #1;
        bus.iStart = 1'b0;
        lat = 1;
        while (!bus.oDone && lat < TIMEOUT) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 11) bus.iStart = 1'b0;
            if (lat == 10) begin
                check("ign_busy", W'(bus.oBusy), 32'd1);
                bus.iStart = 1'b1; bus.iDividend = 32'd50; bus.iDivisor = 32'd5;
            end
        end
        check("ign_lat", W'(lat), 32'd33);
        check("ign_q",   bus.oQuotient,  32'd14);
        check("ign_r",   bus.oRemainder, 32'd2);

        // Synchronous reset at cycle 15 of RUN aborts without a done pulse
        @(negedge clk);
        bus.iStart = 1'b1; bus.iSigned = 1'b1; bus.iDividend = 32'hFFFFFFF9; bus.iDivisor = 32'd2;
        @(posedge clk);
        #1;
        bus.iStart = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", W'(bus.oBusy), '0);
        check("abort_done", W'(bus.oDone), '0);
        check("abort_q",    bus.oQuotient,  '0);
        check("abort_r",    bus.oRemainder, '0);
        done_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.oDone) done_seen++;
        end
        check("abort_no_done", W'(done_seen), '0);
        run_op(1'b0, 32'd1000, 32'd10, lat);
        check("fresh_lat", W'(lat), 32'd33);
        check("fresh_q",   bus.oQuotient,  32'd100);
        check("fresh_r",   bus.oRemainder, 32'd0);

        // A start presented during the DONE cycle is accepted immediately
        run_op(1'b0, 32'd5, 32'd0, lat);
        check("dz_lat", W'(lat), 32'd1);
        bus.iStart = 1'b1; bus.iSigned = 1'b0; bus.iDividend = 32'd81; bus.iDivisor = 32'd9;
        @(posedge clk);
        #1;
        bus.iStart = 1'b0;
        check("b2b_busy", W'(bus.oBusy), 32'd1);
        check("b2b_dz_held", W'(bus.oDivZero), 32'd1);
        lat = 1;
        wait_done(lat);
        check("b2b_lat", W'(lat), 32'd33);
        check("b2b_q",   bus.oQuotient,    32'd9);
        check("b2b_r",   bus.oRemainder,   32'd0);
        check("b2b_dz",  W'(bus.oDivZero), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
